decode_stage: RTL
=================

# decode_stage

Pipelined instruction-decode stage directly upstream of the operand shifter. Registers one fetched 32-bit ARM instruction per cycle along with its register-file operands. Splits the instruction into the field set the shifter and execute stage consume, evaluates the condition code against the current flags, and supports stall and flush from hazard/branch logic.

## Interface
- No parameters.
- clk  input  1  sole clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- instr_valid  input  1  instr/pc/rnData/rmData carry a real instruction this cycle
- instr  input  32  fetched instruction word
- pc  input  32  address of instr
- rnData, rmData  input  32 each  register-file reads for instr[19:16], instr[3:0]
- flags  input  4  current NZCV, bit3=N … bit0=V
- stall  input  1  hold all outputs; not accepting
- flush  input  1  kill the instruction being captured this cycle
- instr_ready  output  1  combinational, = !stall
- ex_valid  output  1  registered outputs describe a live instruction
- undef  output  1  one-cycle pulse: captured instruction unsupported
- opcode  output  5  shifter class/operation code
- immediateOperand  output  1  instr[25]
- shiftType  output  2  instr[6:5]
- rotateVal  output  4  instr[11:8]
- rm_shift  output  5  instr[11:7]
- immediateVal  output  8  instr[7:0]
- immediateOffset  output  12  instr[11:0]
- rm_shiftSDT  output  8  instr[11:4]
- branchOffset  output  24  instr[23:0]
- rd, rn, rm  output  4 each  instr[15:12], [19:16], [3:0]
- setFlags  output  1  S bit instr[20], data-processing only, else 0
- sdtBits  output  5  {P,U,B,W,L} = instr[24:20] for load/store, else 0
- branchLink  output  1  instr[24] for branch, else 0
- condPass  output  1  condition instr[31:28] true against flags
- rnData_q, rmData_q, pc_q  output  32 each  registered operands

## Operation
- Capture occurs when !stall. Captured cycle: ex_valid ← instr_valid & !flush & !unsupported; undef ← instr_valid & !flush & unsupported; all field outputs ← decode(instr).
- Classification (instr[27:25]):
  - 00x, not unsupported → data processing: opcode = {1'b0, instr[24:21]}.
  - 01x → load/store: opcode = 5'b10000.
  - 101 → branch: opcode = 5'b10001.
  - 100, 11x → unsupported.
- Also unsupported: instr[27:22]=000000 with instr[7:4]=1001 (multiply); data processing with instr[25]=0 and instr[4]=1 (register-specified shift).
- Unsupported instruction: ex_valid=0, fields still loaded (don't-care), undef=1.
- Field outputs are raw slices regardless of class; consumers select by opcode.
- condPass from flags sampled in capture cycle: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 → 0.
- Stall: every output register holds; undef forced 0 after its first cycle, so it never repeats while stalled.
- Flush while !stall: ex_valid←0, undef←0.
- Flush with stall: flush wins; ex_valid←0, undef←0, other outputs hold.
- instr_valid=0 (bubble): ex_valid←0, undef←0.

## Timing
- Latency 1: instruction presented at edge k appears on outputs after edge k.
- Throughput 1 instruction/cycle when stall=0.
- Reset: every output register 0 (ex_valid, undef, opcode, all fields, condPass, rnData_q, rmData_q, pc_q). instr_ready stays combinational.
- Reset takes priority over stall and flush. A live instruction is discarded; first capture occurs on the first edge with reset=0.
- No internal multi-cycle state; no instruction is ever duplicated or dropped except by flush, bubble or unsupported.

## Test plan
- Reset held 2 cycles with instr=0xE1A01102, instr_valid=1 → every output 0. First edge after release → ex_valid=1.
- 0xE1A01102 (MOV r1,r2,LSL#2), flags=0 → opcode=01101, immediateOperand=0, shiftType=00, rm_shift=00010, rd=1, rm=2, setFlags=0, condPass=1, one cycle later.
- 0xE5912004 (LDR r2,[r1,#4]) → opcode=10000, immediateOffset=0x004, sdtBits=11001, rd=2, rn=1. Then 0xEAFFFFFE → opcode=10001, branchOffset=0xFFFFFE, branchLink=0.
- 0x01A01102 (MOVEQ): with flags=0000 → condPass=0; with flags=0100 → condPass=1; ex_valid=1 both cases.
- 0xE0010392 (MUL) → ex_valid=0, undef=1 for exactly one cycle. Same instruction with stall raised the cycle after capture → undef=0 while stalled.
- Capture ADD, then stall=1 for 3 cycles while instr changes → outputs frozen, instr_ready=0. Assert flush with stall → ex_valid=0 next edge, fields unchanged. Flush without stall → ex_valid=0.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: one-cycle instruction-decode register stage feeding the
// operand shifter. Splits a fetched 32-bit ARM word into the field set
// consumed downstream, classifies it, evaluates its condition code against
// the current flags, and supports stall/flush from hazard and branch logic.
module decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rnData,
  input  logic [31:0] rmData,
  input  logic [3:0]  flags,
  input  logic        stall,
  input  logic        flush,
  output logic        instr_ready,
  output logic        ex_valid,
  output logic        undef,
  output logic [4:0]  opcode,
  output logic        immediateOperand,
  output logic [1:0]  shiftType,
  output logic [3:0]  rotateVal,
  output logic [4:0]  rm_shift,
  output logic [7:0]  immediateVal,
  output logic [11:0] immediateOffset,
  output logic [7:0]  rm_shiftSDT,
  output logic [23:0] branchOffset,
  output logic [3:0]  rd,
  output logic [3:0]  rn,
  output logic [3:0]  rm,
  output logic        setFlags,
  output logic [4:0]  sdtBits,
  output logic        branchLink,
  output logic        condPass,
  output logic [31:0] rnData_q,
  output logic [31:0] rmData_q,
  output logic [31:0] pc_q
);

  localparam logic [4:0] OP_SDT    = 5'b10000;
  localparam logic [4:0] OP_BRANCH = 5'b10001;

  // Condition-code evaluation; nzcv is {N,Z,C,V}. Code 1111 is never taken.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    logic res;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      4'b0000: res = z;
      4'b0001: res = !z;
      4'b0010: res = c;
      4'b0011: res = !c;
      4'b0100: res = n;
      4'b0101: res = !n;
      4'b0110: res = v;
      4'b0111: res = !v;
      4'b1000: res = c && !z;
      4'b1001: res = !c || z;
      4'b1010: res = (n == v);
      4'b1011: res = (n != v);
      4'b1100: res = !z && (n == v);
      4'b1101: res = z || (n != v);
      4'b1110: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Stage p0: combinational classification of the incoming word
  logic [2:0] cls_p0;
  logic       is_dp_p0;
  logic       is_sdt_p0;
  logic       is_br_p0;
  logic       is_mul_p0;
  logic       is_regshift_p0;
  logic       unsup_p0;
  logic [4:0] opcode_p0;
  logic       cond_p0;
  logic       take_p0;

  // Classify the instruction and derive the class-dependent outputs.
  always_comb begin
    cls_p0         = instr[27:25];
    is_dp_p0       = (cls_p0[2:1] == 2'b00);
    is_sdt_p0      = (cls_p0[2:1] == 2'b01);
    is_br_p0       = (cls_p0 == 3'b101);
    // Multiply shares the data-processing encoding space; 1001 in [7:4]
    // with [27:22] clear marks it.
    is_mul_p0      = (instr[27:22] == 6'b000000) && (instr[7:4] == 4'b1001);
    // Register-specified shift amounts are not handled by the shifter.
    is_regshift_p0 = is_dp_p0 && !instr[25] && instr[4];
    unsup_p0       = (cls_p0 == 3'b100) || (cls_p0[2:1] == 2'b11) ||
                     is_mul_p0 || is_regshift_p0;
    if (is_sdt_p0) begin
      opcode_p0 = OP_SDT;
    end else if (is_br_p0) begin
      opcode_p0 = OP_BRANCH;
    end else begin
      opcode_p0 = {1'b0, instr[24:21]};
    end
    cond_p0 = cond_pass(instr[31:28], flags);
    take_p0 = instr_valid && !flush;
  end

  assign instr_ready = !stall;

  // Stage p1: control registers -- live/undef status of the captured slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid <= 1'b0;
      undef    <= 1'b0;
    end else if (!stall) begin
      ex_valid <= take_p0 && !unsup_p0;
      undef    <= take_p0 && unsup_p0;
    end else begin
      // Held slot: undef is a pulse and must not repeat; a flush still kills.
      undef <= 1'b0;
      if (flush) begin
        ex_valid <= 1'b0;
      end
    end
  end

  // Stage p1: field and operand registers, loaded on every accepted cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      opcode           <= '0;
      immediateOperand <= 1'b0;
      shiftType        <= '0;
      rotateVal        <= '0;
      rm_shift         <= '0;
      immediateVal     <= '0;
      immediateOffset  <= '0;
      rm_shiftSDT      <= '0;
      branchOffset     <= '0;
      rd               <= '0;
      rn               <= '0;
      rm               <= '0;
      setFlags         <= 1'b0;
      sdtBits          <= '0;
      branchLink       <= 1'b0;
      condPass         <= 1'b0;
      rnData_q         <= '0;
      rmData_q         <= '0;
      pc_q             <= '0;
    end else if (!stall) begin
      opcode           <= opcode_p0;
      immediateOperand <= instr[25];
      shiftType        <= instr[6:5];
      rotateVal        <= instr[11:8];
      rm_shift         <= instr[11:7];
      immediateVal     <= instr[7:0];
      immediateOffset  <= instr[11:0];
      rm_shiftSDT      <= instr[11:4];
      branchOffset     <= instr[23:0];
      rd               <= instr[15:12];
      rn               <= instr[19:16];
      rm               <= instr[3:0];
      setFlags         <= is_dp_p0 ? instr[20] : 1'b0;
      sdtBits          <= is_sdt_p0 ? instr[24:20] : 5'b00000;
      branchLink       <= is_br_p0 ? instr[24] : 1'b0;
      condPass         <= cond_p0;
      rnData_q         <= rnData;
      rmData_q         <= rmData;
      pc_q             <= pc;
    end
  end

endmodule
